// File: rtl/hdc_search_pkg.sv
// Shared types and widths for the class hypervector nearest-match search.
package hdc_search_pkg;

  localparam int CLASS_ID_W  = 3;
  localparam int FRAME_IDX_W = 2;
  localparam int DIST_W      = 8;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/hvec_popcount.sv
// Combinational Hamming weight of one hypervector chunk.
module hvec_popcount #(
  parameter int DI_PARALLEL_W_BITS = 64,
  parameter int CNT_W              = $clog2(DI_PARALLEL_W_BITS + 1)
) (
  input  logic [DI_PARALLEL_W_BITS-1:0] vec,
  output logic [CNT_W-1:0]              count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < DI_PARALLEL_W_BITS; i++) begin
      count = count + CNT_W'(vec[i]);
    end
  end

endmodule

// File: rtl/class_hvec_search.sv
// Buffers a query hypervector, scans every class chunk by chunk and reports
// the class with the smallest Hamming distance.
//
//   state  | meaning
//   LOAD   | accepting query chunks into the buffer
//   SEARCH | one class chunk compared per cycle, distances accumulated
//   DONE   | prediction presented until the consumer takes it
module class_hvec_search
  import hdc_search_pkg::*;
#(
  parameter int DI_PARALLEL_W_BITS = 64,
  parameter int N_CLASSES          = 8,
  parameter int N_FRAMES           = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          query_valid,
  output logic                          query_ready,
  input  logic [DI_PARALLEL_W_BITS-1:0] query_chunk,
  output logic [CLASS_ID_W-1:0]         frame_id,
  output logic [FRAME_IDX_W-1:0]        frame_index,
  input  logic [DI_PARALLEL_W_BITS-1:0] class_vec_in,
  output logic                          result_valid,
  input  logic                          result_ready,
  output logic [CLASS_ID_W-1:0]         pred_class,
  output logic [DIST_W-1:0]             pred_dist
);

  localparam int CNT_W = $clog2(DI_PARALLEL_W_BITS + 1);

  state_t                        state, state_nxt;
  logic [DI_PARALLEL_W_BITS-1:0] query_buf [N_FRAMES];
  logic [FRAME_IDX_W-1:0]        q_cnt;
  logic [FRAME_IDX_W-1:0]        frm_cnt;
  logic [CLASS_ID_W-1:0]         cls_cnt;
  logic [CLASS_ID_W-1:0]         min_class;
  logic [DIST_W-1:0]             acc;
  logic [DIST_W-1:0]             min_dist;
  logic [DIST_W-1:0]             total;
  logic [CNT_W-1:0]              chunk_cnt;
  logic [DI_PARALLEL_W_BITS-1:0] xor_chunk;
  logic                          q_accept;
  logic                          q_last;
  logic                          last_frame;
  logic                          last_class;
  logic                          better;

  assign xor_chunk = class_vec_in ^ query_buf[frm_cnt];

  hvec_popcount #(
    .DI_PARALLEL_W_BITS (DI_PARALLEL_W_BITS),
    .CNT_W              (CNT_W)
  ) u_popcount (
    .vec   (xor_chunk),
    .count (chunk_cnt)
  );

  // Total for the current class including the chunk being compared this cycle.
  assign total      = acc + DIST_W'(chunk_cnt);
  assign better     = total < min_dist;
  assign q_accept   = query_valid && query_ready;
  assign q_last     = q_cnt == FRAME_IDX_W'(N_FRAMES - 1);
  assign last_frame = frm_cnt == FRAME_IDX_W'(N_FRAMES - 1);
  assign last_class = cls_cnt == CLASS_ID_W'(N_CLASSES - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    query_ready  = 1'b0;
    result_valid = 1'b0;
    frame_id     = '0;
    frame_index  = '0;
    case (state)
      LOAD: begin
        query_ready = 1'b1;
        if (query_valid && q_last) state_nxt = SEARCH;
      end
      SEARCH: begin
        frame_id    = cls_cnt;
        frame_index = frm_cnt;
        if (last_frame && last_class) state_nxt = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        if (result_ready) state_nxt = LOAD;
      end
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_FRAMES; i++) query_buf[i] <= '0;
      q_cnt      <= '0;
      frm_cnt    <= '0;
      cls_cnt    <= '0;
      acc        <= '0;
      min_dist   <= '0;
      min_class  <= '0;
      pred_class <= '0;
      pred_dist  <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (q_accept) begin
            query_buf[q_cnt] <= query_chunk;
            if (q_last) begin
              q_cnt     <= '0;
              frm_cnt   <= '0;
              cls_cnt   <= '0;
              acc       <= '0;
              min_dist  <= '1;
              min_class <= '0;
            end else begin
              q_cnt <= q_cnt + 1'b1;
            end
          end
        end
        SEARCH: begin
          if (last_frame) begin
            frm_cnt <= '0;
            acc     <= '0;
            if (better) begin
              min_dist  <= total;
              min_class <= cls_cnt;
            end
            // Final class: publish the winner including this class's verdict.
            if (last_class) begin
              cls_cnt    <= '0;
              pred_class <= better ? cls_cnt : min_class;
              pred_dist  <= better ? total : min_dist;
            end else begin
              cls_cnt <= cls_cnt + 1'b1;
            end
          end else begin
            frm_cnt <= frm_cnt + 1'b1;
            acc     <= total;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/class_hvec_search.md
CLASS_HVEC_SEARCH -- requirements
Module: class_hvec_search

Interface
REQ-001 Parameter DI_PARALLEL_W_BITS, default 64: width of one class/query hypervector chunk.
REQ-002 Parameter N_CLASSES, default 8: number of class hypervectors scanned.
REQ-003 Parameter N_FRAMES, default 3: chunks per hypervector.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 query_valid  in  1  query chunk present.
REQ-008 query_ready  out  1  block accepts a query chunk.
REQ-009 query_chunk  in  DI_PARALLEL_W_BITS  query hypervector chunk, frame 0 first.
REQ-010 frame_id  out  3  class select driven to the class vector generator.
REQ-011 frame_index  out  2  chunk select driven to the class vector generator.
REQ-012 class_vec_in  in  DI_PARALLEL_W_BITS  combinational chunk returned for (frame_id, frame_index).
REQ-013 result_valid  out  1  prediction available.
REQ-014 result_ready  in  1  consumer accepts prediction.
REQ-015 pred_class  out  3  class with minimum Hamming distance.
REQ-016 pred_dist  out  8  that minimum distance (max 192).

Function
REQ-017 The FSM SHALL have states LOAD, SEARCH and DONE.
REQ-018 LOAD: query_ready=1; each cycle with query_valid&query_ready SHALL store query_chunk into buffer slot q_cnt and increment q_cnt.
REQ-019 On acceptance of chunk N_FRAMES-1, the FSM SHALL move to SEARCH with class counter=0, frame counter=0, accumulator=0, min_dist=all ones, min_class=0.
REQ-020 SEARCH: frame_id=class counter, frame_index=frame counter; each cycle SHALL add popcount(class_vec_in XOR query_buf[frame counter]) to the accumulator.
REQ-021 Frame counter SHALL wrap 2->0 and then increment the class counter; the per-class total (accumulator + current popcount) SHALL be compared against min_dist at that wrap and the accumulator cleared.
REQ-022 Update SHALL occur only on strictly smaller distance; ties keep the lower class index.
REQ-023 SEARCH SHALL last exactly N_CLASSES*N_FRAMES (24) cycles; result_valid SHALL be high 24 cycles after the edge accepting the last query chunk.
REQ-024 DONE: result_valid=1, pred_class/pred_dist SHALL hold stable until result_valid&result_ready; then return to LOAD with q_cnt=0.
REQ-025 query_ready SHALL be 0 in SEARCH and DONE; query_valid there SHALL be ignored.
REQ-026 frame_id and frame_index SHALL be 0 outside SEARCH.
REQ-027 Distance arithmetic SHALL be unsigned 8-bit, no saturation needed (max 192).

Reset
REQ-028 rst SHALL asynchronously force LOAD, all counters 0, query buffer 0, result_valid=0, pred_class=0, pred_dist=0, frame_id=0, frame_index=0.
REQ-029 rst during SEARCH or DONE SHALL discard the partial query and search; no result is produced.

Structure
REQ-030 A shared package hdc_search_pkg SHALL hold the state enum, CLASS_ID_W=3, FRAME_IDX_W=2, DIST_W=8.
REQ-031 One sub-module hvec_popcount (combinational, DI_PARALLEL_W_BITS in, 7-bit count out) SHALL compute the chunk Hamming weight.

Verification
REQ-032 Bench ROM all zeros except class 3 all ones; query all ones -> pred_class=3, pred_dist=0, result_valid 24 cycles after last chunk.
REQ-033 Bench ROM all classes identical; any query -> pred_class=0 (tie rule).
REQ-034 ROM all zeros, query all ones -> pred_dist=192, pred_class=0.
REQ-035 result_ready held low 10 cycles in DONE -> outputs stable, query_ready=0; ready high -> back to LOAD next cycle.
REQ-036 rst asserted at SEARCH cycle 10, then new query matching class 6 -> only one result, pred_class=6, pred_dist=0.
REQ-037 Monitor frame_id/frame_index in SEARCH -> sequence (0,0),(0,1),(0,2),(1,0)...(7,2), gaps in query_valid tolerated in LOAD.
